des_seq_ctrl: RTL and testbench

DES_SEQ_CTRL -- requirements
Module: des_seq_ctrl

---
 rtl/des_pkg.sv | 27 ++
 rtl/des_shift_sched.sv | 16 +
 rtl/des_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_des_seq_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared types and constants for the DES round sequencer: state encoding,
// round count and the per-round C/D rotate tables for each direction.
package des_pkg;

  localparam int unsigned ROUNDS  = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned SHIFT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Left rotates for encryption; decryption walks the schedule backwards with right rotates
  localparam logic [SHIFT_W-1:0] ENC_SHIFT [ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam logic [SHIFT_W-1:0] DEC_SHIFT [ROUNDS] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

endpackage

// File: rtl/des_shift_sched.sv
// Combinational key-schedule lookup: round index and direction to C/D rotate amount.
module des_shift_sched
  import des_pkg::*;
(
  input  logic [IDX_W-1:0]   i_idx,
  input  logic               i_decrypt,
  output logic [SHIFT_W-1:0] o_key_shift_c
);

  always_comb begin
    o_key_shift_c = '0;
    if (i_decrypt) o_key_shift_c = DEC_SHIFT[i_idx];
    else           o_key_shift_c = ENC_SHIFT[i_idx];
  end

endmodule

// File: rtl/des_seq_ctrl.sv
// DES round sequencer: accepts a start, strobes the datapath load, steps 16
// Feistel rounds with the matching key rotates, then holds the result for handoff.
module des_seq_ctrl #(
  parameter int unsigned ROUNDS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       e,
  input  logic       abort,
  output logic       rnd_ld,
  output logic       rnd_en,
  output logic [3:0] rnd_idx,
  output logic [1:0] key_shift,
  output logic       key_dir,
  output logic       final_swap,
  output logic       busy,
  output logic       done_valid,
  input  logic       done_ready
);
  import des_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  state_t             r_state;
  logic               r_dir;
  logic               r_start_ready;
  logic               r_rnd_ld;
  logic               r_rnd_en;
  logic [IDX_W-1:0]   r_rnd_idx;
  logic [SHIFT_W-1:0] r_key_shift;
  logic               r_key_dir;
  logic               r_final_swap;
  logic               r_busy;
  logic               r_done_valid;

  logic [IDX_W-1:0]   w_nxt_idx;
  logic [SHIFT_W-1:0] w_nxt_shift;

  // Outputs are registered, so the schedule is looked up for the round about to run
  assign w_nxt_idx = (r_state == ST_ROUND) ? IDX_W'(r_rnd_idx + 4'd1) : '0;

  des_shift_sched u_shift_sched (
    .i_idx         (w_nxt_idx),
    .i_decrypt     (~r_dir),
    .o_key_shift_c (w_nxt_shift)
  );

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      r_state       <= ST_IDLE;
      r_dir         <= 1'b0;
      r_start_ready <= 1'b1;
      r_rnd_ld      <= 1'b0;
      r_rnd_en      <= 1'b0;
      r_rnd_idx     <= '0;
      r_key_shift   <= '0;
      r_key_dir     <= 1'b0;
      r_final_swap  <= 1'b0;
      r_busy        <= 1'b0;
      r_done_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_valid) begin
            r_state       <= ST_LOAD;
            r_dir         <= e;
            r_start_ready <= 1'b0;
            r_rnd_ld      <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state      <= ST_ROUND;
          r_rnd_ld     <= 1'b0;
          r_rnd_en     <= 1'b1;
          r_rnd_idx    <= '0;
          r_key_shift  <= w_nxt_shift;
          r_key_dir    <= ~r_dir;
          r_final_swap <= (LAST_IDX == '0);
        end
        ST_ROUND: begin
          if (r_rnd_idx == LAST_IDX) begin
            r_state      <= ST_DONE;
            r_rnd_en     <= 1'b0;
            r_rnd_idx    <= '0;
            r_key_shift  <= '0;
            r_key_dir    <= 1'b0;
            r_final_swap <= 1'b0;
            r_done_valid <= 1'b1;
          end else begin
            r_rnd_idx    <= w_nxt_idx;
            r_key_shift  <= w_nxt_shift;
            r_final_swap <= (w_nxt_idx == LAST_IDX);
          end
        end
        ST_DONE: begin
          if (done_ready) begin
            r_state       <= ST_IDLE;
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_done_valid  <= 1'b0;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_start_ready <= 1'b1;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready = r_start_ready;
  assign rnd_ld      = r_rnd_ld;
  assign rnd_en      = r_rnd_en;
  assign rnd_idx     = r_rnd_idx;
  assign key_shift   = r_key_shift;
  assign key_dir     = r_key_dir;
  assign final_swap  = r_final_swap;
  assign busy        = r_busy;
  assign done_valid  = r_done_valid;

endmodule

// File: tb/tb_des_seq_ctrl.sv
// Directed bench for des_seq_ctrl: full encrypt/decrypt runs, DONE backpressure,
// abort, mid-round reset and abort-versus-start priority.
module tb_des_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start_valid;
  logic       start_ready;
  logic       e;
  logic       abort;
  logic       rnd_ld;
  logic       rnd_en;
  logic [3:0] rnd_idx;
  logic [1:0] key_shift;
  logic       key_dir;
  logic       final_swap;
  logic       busy;
  logic       done_valid;
  logic       done_ready;

  int checks = 0;
  int errors = 0;

  logic [1:0] enc_tbl [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                               2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  logic [1:0] dec_tbl [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                               2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  des_seq_ctrl #(.ROUNDS(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .e           (e),
    .abort       (abort),
    .rnd_ld      (rnd_ld),
    .rnd_en      (rnd_en),
    .rnd_idx     (rnd_idx),
    .key_shift   (key_shift),
    .key_dir     (key_dir),
    .final_swap  (final_swap),
    .busy        (busy),
    .done_valid  (done_valid),
    .done_ready  (done_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {start_ready, rnd_ld, rnd_en, rnd_idx, key_shift, key_dir, final_swap, busy, done_valid}
  function automatic logic [12:0] pack(input logic sr, input logic ld, input logic en,
                                       input logic [3:0] idx, input logic [1:0] ks,
                                       input logic kd, input logic fs, input logic bz,
                                       input logic dv);
    return {sr, ld, en, idx, ks, kd, fs, bz, dv};
  endfunction

  function automatic logic [12:0] obs_vec();
    return pack(start_ready, rnd_ld, rnd_en, rnd_idx, key_shift, key_dir, final_swap,
                busy, done_valid);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [12:0] observed, input logic [12:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %04h expected %04h", tag, observed, expected);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, obs_vec(), pack(1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic chk_round(input string tag, input int i, input logic enc);
    logic [1:0] ks;
    ks = enc ? enc_tbl[i] : dec_tbl[i];
    chk(tag, obs_vec(), pack(1'b0, 1'b0, 1'b1, 4'(i), ks, ~enc, (i == 15), 1'b1, 1'b0));
  endtask

  // Full operation: accept, LOAD, 16 rounds, DONE held `hold` extra cycles, release
  task automatic run_op(input logic enc, input int hold, input bit toggle_e);
    start_valid = 1'b1;
    e = enc;
    step();
    start_valid = 1'b0;
    chk("load", obs_vec(), pack(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 16; i++) begin
      if (toggle_e) e = ~e;
      step();
      chk_round(enc ? "enc_round" : "dec_round", i, enc);
    end
    for (int h = 0; h <= hold; h++) begin
      if (toggle_e) e = ~e;
      step();
      chk("done_hold", obs_vec(), pack(1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    chk_idle("done_release");
  endtask

  initial begin
    rst = 1'b1;
    start_valid = 1'b0;
    e = 1'b0;
    abort = 1'b0;
    done_ready = 1'b0;
    step();
    step();
    chk_idle("reset_state");
    rst = 1'b0;
    step();
    chk_idle("idle_after_reset");

    run_op(1'b1, 0, 1'b0);
    run_op(1'b0, 0, 1'b0);
    run_op(1'b1, 5, 1'b0);
    run_op(1'b1, 1, 1'b1);
    run_op(1'b0, 1, 1'b1);

    // Abort at round 7: back to IDLE, no result ever appears
    start_valid = 1'b1;
    e = 1'b1;
    step();
    start_valid = 1'b0;
    chk("abort_load", obs_vec(), pack(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 8; i++) begin
      step();
      chk_round("abort_round", i, 1'b1);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("abort_idle");
    for (int i = 0; i < 20; i++) begin
      step();
      chk_idle("abort_no_done");
    end
    run_op(1'b1, 0, 1'b0);

    // Reset at round 10 discards the operation
    start_valid = 1'b1;
    e = 1'b0;
    step();
    start_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step();
      chk_round("rst_round", i, 1'b0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("rst_mid_round");
    step();
    chk_idle("rst_stays_idle");

    // Abort beats start in IDLE
    abort = 1'b1;
    start_valid = 1'b1;
    e = 1'b1;
    step();
    chk_idle("abort_vs_start");
    abort = 1'b0;
    start_valid = 1'b0;
    step();
    chk_idle("abort_vs_start_next");

    // Reset while DONE drops done_valid
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    for (int i = 0; i < 17; i++) step();
    chk("pre_rst_done", obs_vec(), pack(1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    rst = 1'b1;
    done_ready = 1'b1;
    step();
    rst = 1'b0;
    done_ready = 1'b0;
    chk_idle("rst_in_done");

    run_op(1'b0, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
